// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared widths and FSM state type for the Wishbone master core
package wb_pkg;

  localparam int ADDR_WIDTH = 16;
  localparam int DATA_WIDTH = 32;
  localparam int GRANULE    = 8;
  localparam int SEL_WIDTH  = DATA_WIDTH / GRANULE;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

endpackage

// File: rtl/wb_timeout_ctr.sv
// rtl/wb_timeout_ctr.sv - cycle counter that flags when a bus cycle has run TIMEOUT cycles
module wb_timeout_ctr #(
  parameter int TIMEOUT = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] r_count;

  // Count cycles of an active bus cycle; clear has priority so each cycle starts at zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_count <= '0;
    end else if (clear_i) begin
      r_count <= '0;
    end else if (enable_i) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Expired in the last allowed cycle, so the FSM leaves on the following edge.
  assign expired_o = (r_count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/wb_master_core.sv
// rtl/wb_master_core.sv - single-transfer Wishbone B4 pipelined master with command/response handshakes
module wb_master_core #(
  parameter  int ADDR_WIDTH = wb_pkg::ADDR_WIDTH,
  parameter  int DATA_WIDTH = wb_pkg::DATA_WIDTH,
  parameter  int GRANULE    = wb_pkg::GRANULE,
  parameter  int TIMEOUT    = 64,
  localparam int SEL_WIDTH  = DATA_WIDTH / GRANULE
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
  input  logic [DATA_WIDTH-1:0] cmd_dat_i,
  input  logic [SEL_WIDTH-1:0]  cmd_sel_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_dat_o,
  output logic                  rsp_err_o,
  output logic                  rsp_timeout_o,
  output logic                  cyc_o,
  output logic                  stb_o,
  output logic                  we_o,
  output logic [ADDR_WIDTH-1:0] adr_o,
  output logic [DATA_WIDTH-1:0] dat_o,
  output logic [SEL_WIDTH-1:0]  sel_o,
  input  logic [DATA_WIDTH-1:0] dat_i,
  input  logic                  ack_i,
  input  logic                  err_i,
  input  logic                  stall_i
);

  import wb_pkg::*;

  state_t                r_state;
  state_t                w_next;
  logic                  w_active;
  logic                  w_expired;
  logic                  w_rsp_load;
  logic                  w_rsp_err;
  logic                  w_rsp_tmo;
  logic [DATA_WIDTH-1:0] w_rsp_dat;

  logic                  r_cyc;
  logic                  r_stb;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_adr;
  logic [DATA_WIDTH-1:0] r_dat;
  logic [SEL_WIDTH-1:0]  r_sel;
  logic                  r_rsp_valid;
  logic                  r_rsp_err;
  logic                  r_rsp_tmo;
  logic [DATA_WIDTH-1:0] r_rsp_dat;

  assign w_active = (r_state == REQ) || (r_state == WAIT);

  wb_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (!w_active),
    .enable_i  (w_active),
    .expired_o (w_expired)
  );

  // State register; reset discards any transfer in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and response capture; a slave response beats the timeout in the same cycle.
  always_comb begin
    w_next     = r_state;
    w_rsp_load = 1'b0;
    w_rsp_err  = 1'b0;
    w_rsp_tmo  = 1'b0;
    w_rsp_dat  = '0;
    case (r_state)
      IDLE: begin
        if (cmd_valid_i) w_next = REQ;
      end
      REQ, WAIT: begin
        if ((r_state == WAIT || !stall_i) && (ack_i || err_i)) begin
          w_next     = RESP;
          w_rsp_load = 1'b1;
          w_rsp_err  = err_i;
          w_rsp_dat  = (!r_we && !err_i) ? dat_i : '0;
        end else if (w_expired) begin
          w_next     = RESP;
          w_rsp_load = 1'b1;
          w_rsp_err  = 1'b1;
          w_rsp_tmo  = 1'b1;
        end else if (r_state == REQ && !stall_i) begin
          w_next = WAIT;
        end
      end
      RESP: begin
        if (rsp_ready_i) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Registered bus and response outputs; bus fields hold the accepted command until the next one.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cyc       <= 1'b0;
      r_stb       <= 1'b0;
      r_we        <= 1'b0;
      r_adr       <= '0;
      r_dat       <= '0;
      r_sel       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_tmo   <= 1'b0;
      r_rsp_dat   <= '0;
    end else begin
      r_cyc <= (w_next == REQ) || (w_next == WAIT);
      r_stb <= (w_next == REQ);
      if (r_state == IDLE && cmd_valid_i) begin
        r_we  <= cmd_we_i;
        r_adr <= cmd_adr_i;
        r_dat <= cmd_dat_i;
        r_sel <= cmd_sel_i;
      end
      if (w_rsp_load) begin
        r_rsp_valid <= 1'b1;
        r_rsp_err   <= w_rsp_err;
        r_rsp_tmo   <= w_rsp_tmo;
        r_rsp_dat   <= w_rsp_dat;
      end else if (r_state == RESP && rsp_ready_i) begin
        r_rsp_valid <= 1'b0;
        r_rsp_err   <= 1'b0;
        r_rsp_tmo   <= 1'b0;
        r_rsp_dat   <= '0;
      end
    end
  end

  assign cmd_ready_o   = (r_state == IDLE);
  assign cyc_o         = r_cyc;
  assign stb_o         = r_stb;
  assign we_o          = r_we;
  assign adr_o         = r_adr;
  assign dat_o         = r_dat;
  assign sel_o         = r_sel;
  assign rsp_valid_o   = r_rsp_valid;
  assign rsp_err_o     = r_rsp_err;
  assign rsp_timeout_o = r_rsp_tmo;
  assign rsp_dat_o     = r_rsp_dat;

endmodule

// File: tb/tb_wb_master_core.sv
// tb/tb_wb_master_core.sv - self-checking bench for wb_master_core against a transaction-level model
module tb_wb_master_core;

  localparam int TMO = 64;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic        cmd_we_i = 1'b0;
  logic [15:0] cmd_adr_i = '0;
  logic [31:0] cmd_dat_i = '0;
  logic [3:0]  cmd_sel_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_dat_o;
  logic        rsp_err_o;
  logic        rsp_timeout_o;
  logic        cyc_o, stb_o, we_o;
  logic [15:0] adr_o;
  logic [31:0] dat_o;
  logic [3:0]  sel_o;
  logic [31:0] dat_i = '0;
  logic        ack_i = 1'b0;
  logic        err_i = 1'b0;
  logic        stall_i = 1'b0;

  int total = 0;
  int bad   = 0;

  wb_master_core #(
    .ADDR_WIDTH (16),
    .DATA_WIDTH (32),
    .GRANULE    (8),
    .TIMEOUT    (TMO)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .cmd_valid_i   (cmd_valid_i),
    .cmd_ready_o   (cmd_ready_o),
    .cmd_we_i      (cmd_we_i),
    .cmd_adr_i     (cmd_adr_i),
    .cmd_dat_i     (cmd_dat_i),
    .cmd_sel_i     (cmd_sel_i),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_ready_i   (rsp_ready_i),
    .rsp_dat_o     (rsp_dat_o),
    .rsp_err_o     (rsp_err_o),
    .rsp_timeout_o (rsp_timeout_o),
    .cyc_o         (cyc_o),
    .stb_o         (stb_o),
    .we_o          (we_o),
    .adr_o         (adr_o),
    .dat_o         (dat_o),
    .sel_o         (sel_o),
    .dat_i         (dat_i),
    .ack_i         (ack_i),
    .err_i         (err_i),
    .stall_i       (stall_i)
  );

  always #5 clk_i = ~clk_i;

  // One transfer. Slave: S stall cycles from REQ entry, response (kind 0 none, 1 ack,
  // 2 err, 3 ack+err) D cycles after the last stall, then R cycles of response backpressure.
  task automatic run_txn(input logic we, input logic [15:0] adr, input logic [31:0] wdat,
                         input logic [3:0] sel, input int s_cyc, input int d_cyc, input int kind,
                         input logic [31:0] rdat, input int r_cyc, input string tag);
    int          c, lat_exp, stb_exp, lat, stb_cnt, unstable, no_cyc, hold_bad;
    logic        tmo_exp, err_exp;
    logic [31:0] dat_exp;
    c = s_cyc + d_cyc;
    if (kind == 0 || c > TMO - 1) begin
      tmo_exp = 1'b1;
      lat_exp = TMO;
    end else begin
      tmo_exp = 1'b0;
      lat_exp = c + 1;
    end
    stb_exp = (s_cyc + 1 < lat_exp) ? s_cyc + 1 : lat_exp;
    err_exp = tmo_exp || (kind >= 2);
    dat_exp = (!we && kind == 1 && !tmo_exp) ? rdat : 32'h0;

    @(negedge clk_i);
    total++;
    if (cmd_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL %s cmd_ready before cmd: got %b want 1", tag, cmd_ready_o);
    end
    cmd_valid_i = 1'b1;
    cmd_we_i    = we;
    cmd_adr_i   = adr;
    cmd_dat_i   = wdat;
    cmd_sel_i   = sel;
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    cmd_we_i    = $urandom_range(0, 1);
    cmd_adr_i   = 16'($urandom);
    cmd_dat_i   = $urandom;
    cmd_sel_i   = 4'($urandom);
    total++;
    if (we_o !== we || adr_o !== adr || dat_o !== wdat || sel_o !== sel) begin
      bad++;
      $display("FAIL %s bus fields: got we=%b adr=%h dat=%h sel=%h want we=%b adr=%h dat=%h sel=%h",
               tag, we_o, adr_o, dat_o, sel_o, we, adr, wdat, sel);
    end

    lat = -1; stb_cnt = 0; unstable = 0; no_cyc = 0;
    for (int k = 0; k < 300; k++) begin
      if (k > 0) @(negedge clk_i);
      if (rsp_valid_o === 1'b1) begin
        lat = k;
        break;
      end
      if (stb_o === 1'b1) begin
        stb_cnt++;
        if (adr_o !== adr || we_o !== we || dat_o !== wdat || sel_o !== sel) unstable++;
      end
      if (cyc_o !== 1'b1) no_cyc++;
      stall_i = (k < s_cyc);
      dat_i   = $urandom;
      ack_i   = 1'b0;
      err_i   = 1'b0;
      if (k < s_cyc) begin
        ack_i = ($urandom_range(0, 3) == 0);
      end else if (k == c) begin
        ack_i = (kind == 1 || kind == 3);
        err_i = (kind >= 2);
        if (kind == 1 && !we) dat_i = rdat;
      end
    end
    stall_i = 1'b0;
    ack_i   = 1'b0;
    err_i   = 1'b0;

    total++;
    if (lat != lat_exp) begin
      bad++;
      $display("FAIL %s latency: got %0d want %0d", tag, lat, lat_exp);
    end
    total++;
    if (stb_cnt != stb_exp || unstable != 0 || no_cyc != 0) begin
      bad++;
      $display("FAIL %s strobe: got stb=%0d unstable=%0d cyc_low=%0d want stb=%0d 0 0",
               tag, stb_cnt, unstable, no_cyc, stb_exp);
    end
    total++;
    if (cyc_o !== 1'b0 || stb_o !== 1'b0) begin
      bad++;
      $display("FAIL %s cyc after done: got cyc=%b stb=%b want 0 0", tag, cyc_o, stb_o);
    end
    total++;
    if (rsp_err_o !== err_exp || rsp_timeout_o !== tmo_exp || rsp_dat_o !== dat_exp) begin
      bad++;
      $display("FAIL %s response: got err=%b tmo=%b dat=%h want err=%b tmo=%b dat=%h",
               tag, rsp_err_o, rsp_timeout_o, rsp_dat_o, err_exp, tmo_exp, dat_exp);
    end

    hold_bad = 0;
    for (int r = 0; r < r_cyc; r++) begin
      @(negedge clk_i);
      if (rsp_valid_o !== 1'b1 || rsp_err_o !== err_exp || rsp_timeout_o !== tmo_exp ||
          rsp_dat_o !== dat_exp || cmd_ready_o !== 1'b0 || cyc_o !== 1'b0) hold_bad++;
    end
    total++;
    if (hold_bad != 0) begin
      bad++;
      $display("FAIL %s response hold: got %0d bad cycles want 0", tag, hold_bad);
    end
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    total++;
    if (rsp_valid_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL %s return idle: got valid=%b ready=%b want 0 1", tag, rsp_valid_o, cmd_ready_o);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk_i);
    total++;
    if (cyc_o !== 1'b0 || stb_o !== 1'b0 || we_o !== 1'b0 || adr_o !== 16'h0 || dat_o !== 32'h0 ||
        sel_o !== 4'h0 || rsp_valid_o !== 1'b0 || rsp_err_o !== 1'b0 || rsp_timeout_o !== 1'b0 ||
        rsp_dat_o !== 32'h0) begin
      bad++;
      $display("FAIL reset_outputs: got cyc=%b stb=%b we=%b adr=%h dat=%h sel=%h v=%b e=%b t=%b rd=%h want all 0",
               cyc_o, stb_o, we_o, adr_o, dat_o, sel_o, rsp_valid_o, rsp_err_o, rsp_timeout_o, rsp_dat_o);
    end
    rst_i = 1'b0;
    #1;
    total++;
    if (cmd_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_ready: got %b want 1", cmd_ready_o);
    end
  endtask

  task automatic test_write_basic;
    run_txn(1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 0, 1, 1, 32'h0, 0, "write_basic");
  endtask

  task automatic test_read_stall;
    run_txn(1'b0, 16'h0004, 32'h0, 4'hF, 3, 0, 1, 32'h12345678, 0, "read_stall");
  endtask

  task automatic test_err;
    run_txn(1'b0, 16'h0020, 32'h0, 4'hF, 0, 1, 3, 32'hCAFEF00D, 0, "ack_err_both");
    run_txn(1'b1, 16'h0024, 32'h55AA55AA, 4'h3, 1, 0, 2, 32'h0, 0, "err_in_req");
  endtask

  task automatic test_timeout;
    run_txn(1'b0, 16'h0030, 32'h0, 4'hF, 0, 0, 0, 32'h0, 0, "timeout_wait");
    run_txn(1'b0, 16'h0034, 32'h0, 4'hF, 70, 0, 1, 32'h0, 0, "timeout_stall");
    run_txn(1'b0, 16'h0038, 32'h0, 4'hF, 2, 61, 1, 32'hA5A5A5A5, 0, "ack_last_cycle");
    run_txn(1'b0, 16'h003C, 32'h0, 4'hF, 0, 64, 1, 32'hA5A5A5A5, 0, "ack_too_late");
  endtask

  task automatic test_rsp_backpressure;
    run_txn(1'b0, 16'h0040, 32'h0, 4'hF, 1, 2, 1, 32'h0BADF00D, 5, "backpressure");
  endtask

  task automatic test_reset_mid;
    int seen;
    @(negedge clk_i);
    cmd_valid_i = 1'b1;
    cmd_we_i    = 1'b0;
    cmd_adr_i   = 16'h0050;
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    stall_i     = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    total++;
    if (cyc_o !== 1'b1 || stb_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_in_wait: got cyc=%b stb=%b want 1 0", cyc_o, stb_o);
    end
    #2 rst_i = 1'b1;
    #1;
    total++;
    if (cyc_o !== 1'b0 || stb_o !== 1'b0 || rsp_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_async: got cyc=%b stb=%b valid=%b want 0 0 0", cyc_o, stb_o, rsp_valid_o);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    ack_i = 1'b1;
    seen  = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      if (rsp_valid_o !== 1'b0 || cyc_o !== 1'b0) seen++;
    end
    ack_i = 1'b0;
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL reset_mid_no_rsp: got %0d cycles with activity want 0", seen);
    end
    run_txn(1'b1, 16'h0054, 32'h01020304, 4'h5, 0, 1, 1, 32'h0, 0, "after_reset");
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 4; i++)
      run_txn(i[0], 16'h0100 + 16'(i * 4), $urandom, 4'hF, 0, 0, 1, $urandom, 0, "back_to_back");
  endtask

  task automatic test_random;
    int sel_kind, kind;
    for (int i = 0; i < 30; i++) begin
      sel_kind = $urandom_range(0, 9);
      kind = (sel_kind == 0) ? 0 : (sel_kind <= 6) ? 1 : (sel_kind <= 8) ? 2 : 3;
      run_txn(1'($urandom_range(0, 1)), 16'($urandom), $urandom, 4'($urandom),
              $urandom_range(0, 4), $urandom_range(0, 3), kind, $urandom,
              $urandom_range(0, 3), "random");
    end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_read_stall();
    test_err();
    test_timeout();
    test_rsp_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_master_core.md
WB_MASTER_CORE -- requirements
Module: wb_master_core

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, SHALL set the Wishbone address width.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the Wishbone data width.
REQ-003 Parameter GRANULE, default 8, SHALL set the select granularity; SEL_WIDTH = DATA_WIDTH/GRANULE.
REQ-004 Parameter TIMEOUT, default 64, SHALL set the maximum cycles from cycle start to ack/err.
REQ-005 clk_i  in  1  SHALL be the single clock; all logic rises on posedge clk_i.
REQ-006 rst_i  in  1  SHALL be the asynchronous, active-high reset.
REQ-007 cmd_valid_i in 1, cmd_ready_o out 1: SHALL form the command handshake.
REQ-008 cmd_we_i in 1, cmd_adr_i in ADDR_WIDTH, cmd_dat_i in DATA_WIDTH, cmd_sel_i in SEL_WIDTH: SHALL be the command fields.
REQ-009 rsp_valid_o out 1, rsp_ready_i in 1: SHALL form the response handshake.
REQ-010 rsp_dat_o out DATA_WIDTH, rsp_err_o out 1, rsp_timeout_o out 1: SHALL be the response fields.
REQ-011 cyc_o, stb_o, we_o out 1; adr_o out ADDR_WIDTH; dat_o out DATA_WIDTH; sel_o out SEL_WIDTH: SHALL be the Wishbone B4 pipelined master outputs.
REQ-012 dat_i in DATA_WIDTH; ack_i, err_i, stall_i in 1: SHALL be the slave response inputs.

Function
REQ-013 The FSM SHALL have states IDLE, REQ, WAIT, RESP.
REQ-014 IDLE: cmd_ready_o=1; on cmd_valid_i, it SHALL register the command fields and go to REQ.
REQ-015 REQ: cyc_o=1, stb_o=1, with we_o/adr_o/dat_o/sel_o driven from the registered command; if stall_i=0, go to WAIT next cycle; if stall_i=1, stay with all outputs held stable.
REQ-016 WAIT: cyc_o=1, stb_o=0; on ack_i or err_i, go to RESP.
REQ-017 ack_i/err_i asserted in REQ with stall_i=0 SHALL complete the transfer directly (REQ->RESP); with stall_i=1 they SHALL be ignored.
REQ-018 Simultaneous ack_i and err_i SHALL be treated as an error: rsp_err_o=1.
REQ-019 On a read ack, rsp_dat_o SHALL capture dat_i; on a write or error, rsp_dat_o SHALL be 0.
REQ-020 The timeout counter SHALL clear on entry to REQ and increment each cycle in REQ/WAIT; when it reaches TIMEOUT-1 without ack/err, go to RESP with rsp_err_o=1 and rsp_timeout_o=1.
REQ-021 RESP: cyc_o=0, stb_o=0, rsp_valid_o=1, with fields held; on rsp_ready_i, go to IDLE.
REQ-022 cyc_o SHALL deassert in the cycle after ack/err/timeout; no stb_o SHALL be issued outside cyc_o.
REQ-023 Minimum latency SHALL be: command accept -> stb_o 1 cycle; ack at first WAIT cycle -> rsp_valid_o next cycle.
REQ-024 Outputs SHALL be registered, except cmd_ready_o, which SHALL be decoded from state.

Reset
REQ-025 On rst_i, the block SHALL enter IDLE asynchronously; cyc_o, stb_o, we_o, rsp_valid_o, rsp_err_o and rsp_timeout_o SHALL be 0; adr_o, dat_o, sel_o, rsp_dat_o and the counter SHALL be 0.
REQ-026 Reset mid-transfer SHALL drop cyc_o/stb_o immediately and discard the transfer, with no response generated.
REQ-027 After reset release, cmd_ready_o SHALL be 1 at the first clock edge.

Structure
REQ-028 Package wb_pkg SHALL hold ADDR_WIDTH, DATA_WIDTH, GRANULE, SEL_WIDTH and the FSM state enum type.
REQ-029 The timeout counter SHALL be a sub-module wb_timeout_ctr (clear, enable, expired).

Verification
REQ-030 Write adr=0x0010, dat=0xDEADBEEF, sel=0xF, with slave stall_i=0 and ack next cycle -> one stb_o cycle, we_o=1, rsp_err_o=0, rsp_dat_o=0.
REQ-031 Read adr=0x0004, stall_i=1 for 3 cycles, then ack with dat_i=0x12345678 -> stb_o held for 4 cycles with adr stable, rsp_dat_o=0x12345678.
REQ-032 Read with err_i=1 (ack_i=1 same cycle) -> rsp_err_o=1, rsp_timeout_o=0, cyc_o low next cycle.
REQ-033 Read with no ack, TIMEOUT=64 -> rsp_valid_o=1 with rsp_err_o=1 and rsp_timeout_o=1 exactly 64 cycles after REQ entry.
REQ-034 rsp_ready_i=0 for 5 cycles -> rsp fields stable, cmd_ready_o=0; then ready -> IDLE.
REQ-035 rst_i pulse while in WAIT -> cyc_o=0 asynchronously, no rsp_valid_o, and the next command proceeds normally.
